vga_fb_arb: RTL and testbench

VGA_FB_ARB -- requirements
Module: vga_fb_arb

---
 rtl/vga_fb_arb.sv | 144 ++++++++++++++
 tb/tb_vga_fb_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arb.sv
// vga_fb_arb: shares a single-port frame buffer between display reads (absolute priority while blank is low)
// and camera writes queued in a small FIFO. Define FB_ARB_DROP_CNT_EN for the stalled-camera-cycle counter.
module vga_fb_arb #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int FRAME_PX = 307200,
  parameter int WF_DEPTH = 8
) (
  input  logic              px_clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              vs,
  input  logic              cam_valid,
  output logic              cam_ready,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  output logic [15:0]       drop_cnt
);
  localparam int PW = $clog2(WF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_PX = ADDR_W'(FRAME_PX - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;

  logic [ADDR_W+DATA_W-1:0] fifo_q [WF_DEPTH];
  logic [PW-1:0]     wr_idx_q, rd_idx_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic              px_valid_q;
  logic [DATA_W-1:0] px_data_q;
  logic              push, pop;

  assign cam_ready = (cnt_q < CW'(WF_DEPTH));
  assign push      = cam_valid & cam_ready;
  // A WRITE state entered on the last entry can see an empty FIFO; it then acts as IDLE.
  assign pop       = (state_q == WRITE) && (cnt_q != '0);

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (!blank)            state_d = READ;
    else if (cnt_q != '0)  state_d = WRITE;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_vld_d    = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    if (pop) begin
      {mem_addr_d, mem_wdata_d} = fifo_q[rd_idx_q];
      mem_we_d = 1'b1;
    end else if (state_q == READ) begin
      mem_addr_d = rd_ptr_q;
      rd_vld_d   = 1'b1;
      rd_ptr_d   = (rd_ptr_q == LAST_PX) ? '0 : rd_ptr_q + 1'b1;
    end
    if (vs) rd_ptr_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (push) fifo_q[wr_idx_q] <= {cam_addr, cam_data};
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      px_valid_q  <= 1'b0;
      px_data_q   <= '0;
    end else begin
      if (push) wr_idx_q <= wr_idx_q + 1'b1;
      if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= rd_vld_d;
      px_valid_q  <= rd_vld_q;
      px_data_q   <= px_data;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign px_valid  = px_valid_q;
  // RAM data arrives the cycle after the read address; pass it straight through, hold it otherwise.
  assign px_data   = px_valid_q ? mem_rdata : px_data_q;

`ifdef FB_ARB_DROP_CNT_EN
  logic        vs_q;
  logic [15:0] drop_q;

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      vs_q   <= 1'b0;
      drop_q <= '0;
    end else begin
      vs_q <= vs;
      if (vs && !vs_q)
        drop_q <= '0;
      else if (cam_valid && !cam_ready && drop_q != 16'hFFFF)
        drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_fb_arb.sv
// Randomized and directed bench for vga_fb_arb against a queue-based reference model with a behavioural RAM.
module tb_vga_fb_arb;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int FP = 16;
  localparam int WD = 8;
`ifdef FB_ARB_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          px_clk = 1'b0;
  logic          rst, blank, vs, cam_valid, cam_ready, mem_we, px_valid;
  logic [AW-1:0] cam_addr, mem_addr;
  logic [DW-1:0] cam_data, mem_wdata, mem_rdata, px_data;
  logic [15:0]   drop_cnt;

  always #5 px_clk = ~px_clk;

  vga_fb_arb #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PX(FP), .WF_DEPTH(WD)) dut (
    .px_clk(px_clk), .rst(rst), .blank(blank), .vs(vs),
    .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_addr(cam_addr), .cam_data(cam_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .px_data(px_data), .px_valid(px_valid), .drop_cnt(drop_cnt)
  );

  // behavioural single-port RAM, read-first, one cycle read latency
  logic [DW-1:0] ram [256];
  always @(posedge px_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int n_we  = 0;
  int n_pxv = 0;

  // reference model state
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    ref_mem [256];
  int               m_act;  // what the bus does next cycle: 0 nothing, 1 drain one write, 2 display read
  int               m_ptr;
  logic [AW-1:0]    e_addr;
  logic             e_we, e_rdv, e_pxv, vs_prev;
  logic [DW-1:0]    e_wdata, e_rdd, e_pxd;
  int               e_drop;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit b, input bit v, input bit cv);
    blank     = b;
    vs        = v;
    cam_valid = cv;
    cam_addr  = AW'($urandom);
    cam_data  = DW'($urandom);
  endtask

  task automatic model_reset();
    wq.delete();
    m_act = 0; m_ptr = 0; e_addr = '0; e_we = 0; e_rdv = 0; e_pxv = 0; vs_prev = 0;
    e_wdata = '0; e_rdd = '0; e_pxd = '0; e_drop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pxv", 32'(px_valid), 32'd0);
    chk("rst_pxd", 32'(px_data), 32'd0);
    chk("rst_rdy", 32'(cam_ready), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    model_reset();
    @(posedge px_clk);
    #1;
    rst = 1'b0;
  endtask

  // Advance one clock: predict what the edge does from the current inputs, then compare.
  task automatic step();
    int               cnt;
    bit               rdy;
    logic [AW+DW-1:0] h;
    cnt = wq.size();
    rdy = (cnt < WD);
    // pixel out next cycle is whatever the RAM returns for this cycle's read address
    if (e_rdv) e_pxd = e_rdd;
    e_pxv = e_rdv;
    if (DROP_EN) begin
      if (vs && !vs_prev) e_drop = 0;
      else if (cam_valid && !rdy && e_drop < 65535) e_drop++;
    end
    vs_prev = vs;
    if (m_act == 1 && cnt > 0) begin
      h = wq.pop_front();
      e_we = 1; e_rdv = 0;
      e_addr = h[AW+DW-1:DW];
      e_wdata = h[DW-1:0];
      ref_mem[e_addr] = e_wdata;
    end else if (m_act == 2) begin
      e_we = 0; e_rdv = 1;
      e_addr = AW'(m_ptr);
      e_rdd = ref_mem[m_ptr];
      m_ptr = (m_ptr + 1) % FP;
    end else begin
      e_we = 0; e_rdv = 0;
    end
    if (vs) m_ptr = 0;
    if (cam_valid && rdy) wq.push_back({cam_addr, cam_data});
    m_act = !blank ? 2 : (cnt > 0 ? 1 : 0);
    @(posedge px_clk);
    #1;
    chk("we", 32'(mem_we), 32'(e_we));
    chk("addr", 32'(mem_addr), 32'(e_addr));
    chk("wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("pxv", 32'(px_valid), 32'(e_pxv));
    chk("pxd", 32'(px_data), 32'(e_pxd));
    chk("rdy", 32'(cam_ready), 32'(wq.size() < WD));
    chk("drop", 32'(drop_cnt), 32'(e_drop));
    if (mem_we === 1'b1) n_we++;
    if (px_valid === 1'b1) n_pxv++;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    #2;
    do_reset();

    // reset with three writes queued and blank high
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1); step(); end
    drive(1, 0, 0); step();
    chk("q3_before_rst", 32'(wq.size()), 32'd3);
    do_reset();
    n_we = 0;
    for (int i = 0; i < 6; i++) begin drive(1, 0, 0); step(); end
    chk("rst_no_we", 32'(n_we), 32'd0);

    // vs pulse then a 640-pixel line
    drive(1, 1, 0); step();
    n_pxv = 0;
    for (int i = 0; i < 640; i++) begin drive(0, 0, 0); step(); end
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0); step(); end
    chk("line_px", 32'(n_pxv), 32'd640);

    // fill while reading, then drain during blank
    for (int i = 0; i < 8; i++) begin drive(0, 0, 1); step(); end
    chk("full_rdy", 32'(cam_ready), 32'd0);
    drive(0, 0, 1); step();
    n_we = 0;
    for (int i = 0; i < 12; i++) begin drive(1, 0, 0); step(); end
    chk("drain_we", 32'(n_we), 32'd8);

    // preemption: one write completes, four resume later
    for (int i = 0; i < 5; i++) begin drive(0, 0, 1); step(); end
    n_we = 0;
    drive(1, 0, 0); step();
    for (int i = 0; i < 6; i++) begin drive(0, 0, 0); step(); end
    chk("preempt_we", 32'(n_we), 32'd1);
    n_we = 0;
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0); step(); end
    chk("resume_we", 32'(n_we), 32'd4);

    // read pointer wrap without vs
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(0, 0, 0); step(); end
    chk("wrap_last", 32'(mem_addr), 32'd2);

    // drop counter
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(0, 0, 1); step(); end
    for (int i = 0; i < 10; i++) begin drive(0, 0, 1); step(); end
    chk("drop10", 32'(drop_cnt), DROP_EN ? 32'd10 : 32'd0);
    drive(0, 1, 0); step();
    chk("drop_clr", 32'(drop_cnt), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
